// File: rtl/pau_sched_pkg.sv
// Shared types and helpers for the PAU operation scheduler: FSM states, op codes,
// per-op settle latency and the posit NaR pattern.
package pau_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    function automatic int unsigned op_latency(input op_t op,
                                               input int unsigned lat_add,
                                               input int unsigned lat_mul,
                                               input int unsigned lat_div);
        case (op)
            OP_MUL:  return lat_mul;
            OP_DIV:  return lat_div;
            default: return lat_add;
        endcase
    endfunction

    // Posit NaR is the sign bit alone; callers truncate to their posit width.
    function automatic logic [63:0] nar_value(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/pau_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above the
// pointer, wrapping around, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);
    localparam int IDW = $clog2(NREQ);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pau_op_scheduler.sv
// Shares one posit arithmetic unit among NREQ requesters with round-robin issue.
// Define PAU_SCHED_TIMEOUT_EN to abort ops whose done flag never arrives (returns NaR, rsp_err=1).
module pau_op_scheduler
    import pau_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int PAU_N   = 16,
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 12,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [2*NREQ-1:0]         req_op,
    input  logic [PAU_N*NREQ-1:0]     req_a,
    input  logic [PAU_N*NREQ-1:0]     req_b,
    output logic                      pau_start,
    output logic [1:0]                pau_op,
    output logic [PAU_N-1:0]          pau_a,
    output logic [PAU_N-1:0]          pau_b,
    input  logic [PAU_N-1:0]          pau_result,
    input  logic                      pau_done,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [PAU_N-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);
    localparam int IDW     = $clog2(NREQ);
    localparam int MAX_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int MAX_LAT = (LAT_DIV > MAX_AM) ? LAT_DIV : MAX_AM;
    localparam int CW      = $clog2(MAX_LAT + TIMEOUT + 1);

    state_t             state;
    op_t                op_q;
    logic [PAU_N-1:0]   a_q;
    logic [PAU_N-1:0]   b_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     rr_ptr;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      lat_cur;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign lat_cur   = CW'(op_latency(op_q, LAT_ADD, LAT_MUL, LAT_DIV));
    // Gating with rst keeps req_ready low while reset is held, even if requesters are valid.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign pau_start = (state == EXEC);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign pau_op    = op_q;
    assign pau_a     = a_q;
    assign pau_b     = b_q;
    assign rsp_id    = id_q;

`ifdef PAU_SCHED_TIMEOUT_EN
    localparam logic [PAU_N-1:0] NAR = PAU_N'(nar_value(PAU_N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    op_q   <= op_t'(req_op[2*grant_idx +: 2]);
                    a_q    <= req_a[PAU_N*grant_idx +: PAU_N];
                    b_q    <= req_b[PAU_N*grant_idx +: PAU_N];
                    id_q   <= grant_idx;
                    cnt    <= '0;
                    rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    state  <= EXEC;
                end
                EXEC: begin
                    if (cnt < lat_cur) begin
                        cnt <= cnt + CW'(1);
                    end else if (pau_done) begin
                        rsp_data <= pau_result;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == lat_cur + CW'(TIMEOUT)) begin
                        rsp_data <= NAR;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign rsp_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    op_q   <= op_t'(req_op[2*grant_idx +: 2]);
                    a_q    <= req_a[PAU_N*grant_idx +: PAU_N];
                    b_q    <= req_b[PAU_N*grant_idx +: PAU_N];
                    id_q   <= grant_idx;
                    cnt    <= '0;
                    rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                    state  <= EXEC;
                end
                EXEC: begin
                    if (cnt < lat_cur) begin
                        cnt <= cnt + CW'(1);
                    end else if (pau_done) begin
                        rsp_data <= pau_result;
                        state    <= RESP;
                    end
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pau_op_scheduler.sv
// Self-checking bench for pau_op_scheduler: PAU model with programmable done delay
// and a round-robin / latency reference model computed from the scheduling rules.
module tb_pau_op_scheduler;
    localparam int NREQ    = 4;
    localparam int PAU_N   = 16;
    localparam int IDW     = 2;
    localparam int LAT_ADD = 3;
    localparam int LAT_MUL = 4;
    localparam int LAT_DIV = 12;
    localparam int TIMEOUT = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op = '0;
    logic [PAU_N*NREQ-1:0] req_a = '0;
    logic [PAU_N*NREQ-1:0] req_b = '0;
    logic                  pau_start;
    logic [1:0]            pau_op;
    logic [PAU_N-1:0]      pau_a;
    logic [PAU_N-1:0]      pau_b;
    logic [PAU_N-1:0]      pau_result;
    logic                  pau_done;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [PAU_N-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;
    int done_thresh = 0;
    int exec_cnt    = 0;
    int cycle_cnt   = 0;
    bit fixed_en    = 1'b0;
    logic [PAU_N-1:0] fixed_val = '0;

    pau_op_scheduler #(
        .NREQ(NREQ), .PAU_N(PAU_N), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .pau_start(pau_start),
        .pau_op(pau_op), .pau_a(pau_a), .pau_b(pau_b), .pau_result(pau_result),
        .pau_done(pau_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // PAU model: done rises once start has been high for done_thresh cycles.
    always @(posedge clk or posedge rst) begin
        if (rst)            exec_cnt <= 0;
        else if (pau_start) exec_cnt <= exec_cnt + 1;
        else                exec_cnt <= 0;
    end

    function automatic logic [15:0] pau_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b10:   return LAT_MUL;
            2'b11:   return LAT_DIV;
            default: return LAT_ADD;
        endcase
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    assign pau_done   = pau_start && (exec_cnt >= done_thresh);
    assign pau_result = fixed_en ? fixed_val : pau_fn(pau_a, pau_b, pau_op);

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_ptr = 0;
    endtask

    // Drives one request set from IDLE and records what the DUT does; no comparisons here.
    task automatic run_txn(input logic [NREQ-1:0] valid, input int rsp_delay, input bit keep_valid,
                           output logic [NREQ-1:0] o_ready, output int o_lat, output int o_gcyc,
                           output logic [IDW-1:0] o_id, output logic [15:0] o_data,
                           output logic o_err, output bit o_start_ok, output logic [1:0] o_op,
                           output logic [15:0] o_a, output logic [15:0] o_b,
                           output bit o_stable, output bit o_idle);
        req_valid = valid;
        #1;
        o_ready = req_ready;
        o_gcyc  = cycle_cnt;
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = '0;
        #1;
        o_op = pau_op; o_a = pau_a; o_b = pau_b;
        o_lat = 1; o_start_ok = 1'b1;
        while (!rsp_valid && o_lat < 300) begin
            if (!pau_start || req_ready !== '0) o_start_ok = 1'b0;
            @(posedge clk);
            #2;
            o_lat++;
        end
        if (!rsp_valid) o_lat = -1;
        o_id = rsp_id; o_data = rsp_data; o_err = rsp_err; o_stable = 1'b1;
        for (int d = 0; d < rsp_delay; d++) begin
            @(posedge clk);
            #2;
            if (!rsp_valid || rsp_id !== o_id || rsp_data !== o_data || rsp_err !== o_err ||
                !busy || req_ready !== '0) o_stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        #1 o_idle = !busy && !rsp_valid;
    endtask

    task automatic test_reset();
        req_valid = '1;
        rst = 1'b1;
        #3;
        vectors++;
        if ({req_ready, pau_start, pau_op, pau_a, pau_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 60'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: req_ready=%b busy=%b pau_start=%b rsp_valid=%b, required all zero",
                     req_ready, busy, pau_start, rsp_valid);
        end
        repeat (2) @(posedge clk);
        #2 req_valid = '0;
        rst = 1'b0;
        model_ptr = 0;
        #1;
        vectors++;
        if ({req_ready, pau_start, pau_op, pau_a, pau_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 60'd0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: busy=%b rsp_valid=%b, required zero", busy, rsp_valid);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_add();
        logic [NREQ-1:0] rdy; int lat, gc; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op;
        req_op = '0;
        req_a[2*PAU_N +: PAU_N] = 16'h4000;
        req_b[2*PAU_N +: PAU_N] = 16'h5000;
        fixed_en = 1'b1; fixed_val = 16'h5800; done_thresh = 0;
        run_txn(4'b0100, 0, 1'b0, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
        fixed_en = 1'b0;
        vectors++; if (rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL add_ready: got %b required 0100", rdy); end
        vectors++; if (lat != 5) begin miscompares++; $display("[TB] FAIL add_latency: got %0d required 5", lat); end
        vectors++; if (id !== 2'd2) begin miscompares++; $display("[TB] FAIL add_id: got %0d required 2", id); end
        vectors++; if (dat !== 16'h5800) begin miscompares++; $display("[TB] FAIL add_data: got %h required 5800", dat); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL add_err: got %b required 0", err); end
        vectors++; if ({op, a, b} !== {2'b00, 16'h4000, 16'h5000}) begin
            miscompares++; $display("[TB] FAIL add_operands: got op=%b a=%h b=%h required 00/4000/5000", op, a, b); end
        vectors++; if (!sok || !idl) begin miscompares++; $display("[TB] FAIL add_exec_idle: start_ok=%b idle=%b required 1/1", sok, idl); end
        model_ptr = 3;
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] rdy; int lat, gc, prev_gc; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op; int g;
        req_op = 8'b10101010;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*PAU_N +: PAU_N] = 16'($urandom);
            req_b[i*PAU_N +: PAU_N] = 16'($urandom);
        end
        prev_gc = 0;
        for (int t = 0; t < 5; t++) begin
            g = t % NREQ;
            run_txn('1, 0, 1'b1, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
            vectors++; if (rdy !== 4'(1 << g)) begin miscompares++; $display("[TB] FAIL rr_grant[%0d]: got %b required one-hot %0d", t, rdy, g); end
            vectors++; if (lat != LAT_MUL + 2) begin miscompares++; $display("[TB] FAIL rr_latency[%0d]: got %0d required %0d", t, lat, LAT_MUL + 2); end
            vectors++; if (dat !== pau_fn(req_a[g*PAU_N +: PAU_N], req_b[g*PAU_N +: PAU_N], 2'b10) || id !== IDW'(g)) begin
                miscompares++; $display("[TB] FAIL rr_rsp[%0d]: got id=%0d data=%h required id=%0d", t, id, dat, g); end
            if (t > 0) begin
                vectors++; if (gc - prev_gc != LAT_MUL + 3) begin miscompares++; $display("[TB] FAIL rr_spacing[%0d]: got %0d required %0d", t, gc - prev_gc, LAT_MUL + 3); end
            end
            prev_gc = gc;
        end
        req_valid = '0;
        model_ptr = 1;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] rdy; int lat, gc; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op; int g;
        req_op = '0;
        g = model_grant(4'b1001, model_ptr);
        run_txn(4'b1001, 10, 1'b1, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
        req_valid = '0;
        vectors++; if (rdy !== 4'(1 << g)) begin miscompares++; $display("[TB] FAIL bp_grant: got %b required one-hot %0d", rdy, g); end
        vectors++; if (!stb) begin miscompares++; $display("[TB] FAIL bp_stable: got %b required 1", stb); end
        vectors++; if (!idl) begin miscompares++; $display("[TB] FAIL bp_idle_after: got %b required 1", idl); end
        vectors++; if (id !== IDW'(g) || dat !== pau_fn(req_a[g*PAU_N +: PAU_N], req_b[g*PAU_N +: PAU_N], 2'b00)) begin
            miscompares++; $display("[TB] FAIL bp_rsp: got id=%0d data=%h required id=%0d", id, dat, g); end
        model_ptr = (g + 1) % NREQ;
    endtask

    task automatic test_late_div();
        logic [NREQ-1:0] rdy; int lat, gc; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op;
        req_op[2 +: 2] = 2'b11;
        req_a[PAU_N +: PAU_N] = 16'h3a5c;
        req_b[PAU_N +: PAU_N] = 16'h4411;
        done_thresh = LAT_DIV + 3;
        run_txn(4'b0010, 0, 1'b0, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
        done_thresh = 0;
        vectors++; if (lat != LAT_DIV + 5) begin miscompares++; $display("[TB] FAIL div_late_latency: got %0d required %0d", lat, LAT_DIV + 5); end
        vectors++; if (!sok) begin miscompares++; $display("[TB] FAIL div_start_held: got %b required 1", sok); end
        vectors++; if (dat !== (16'h3a5c ^ 16'h4411) || id !== 2'd1 || op !== 2'b11) begin
            miscompares++; $display("[TB] FAIL div_rsp: got id=%0d data=%h op=%b required 1/%h/11", id, dat, op, 16'h3a5c ^ 16'h4411); end
        model_ptr = 2;
    endtask

`ifdef PAU_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [NREQ-1:0] rdy; int lat, gc; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op;
        req_op[4 +: 2] = 2'b00;
        done_thresh = 1000000;
        run_txn(4'b0100, 0, 1'b0, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
        done_thresh = 0;
        vectors++; if (lat != LAT_ADD + TIMEOUT + 2) begin miscompares++; $display("[TB] FAIL timeout_latency: got %0d required %0d", lat, LAT_ADD + TIMEOUT + 2); end
        vectors++; if (err !== 1'b1 || dat !== 16'h8000) begin
            miscompares++; $display("[TB] FAIL timeout_rsp: got err=%b data=%h required 1/8000", err, dat); end
        model_ptr = 3;
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] rdy, v; int lat, gc, g, l, exp_lat; logic [IDW-1:0] id; logic [15:0] dat, a, b;
        logic err; bit sok, stb, idl; logic [1:0] op;
        for (int t = 0; t < 24; t++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_op = 8'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*PAU_N +: PAU_N] = 16'($urandom);
                req_b[i*PAU_N +: PAU_N] = 16'($urandom);
            end
            g = model_grant(v, model_ptr);
            l = lat_of(req_op[2*g +: 2]);
            done_thresh = $urandom_range(0, l + 4);
            exp_lat = ((done_thresh > l) ? done_thresh : l) + 2;
            run_txn(v, $urandom_range(0, 3), 1'b0, rdy, lat, gc, id, dat, err, sok, op, a, b, stb, idl);
            vectors++; if (rdy !== 4'(1 << g)) begin miscompares++; $display("[TB] FAIL rand_grant[%0d]: got %b required one-hot %0d", t, rdy, g); end
            vectors++; if (lat != exp_lat) begin miscompares++; $display("[TB] FAIL rand_latency[%0d]: got %0d required %0d", t, lat, exp_lat); end
            vectors++; if (id !== IDW'(g) || err !== 1'b0 ||
                           dat !== pau_fn(req_a[g*PAU_N +: PAU_N], req_b[g*PAU_N +: PAU_N], req_op[2*g +: 2])) begin
                miscompares++; $display("[TB] FAIL rand_rsp[%0d]: got id=%0d data=%h err=%b required id=%0d", t, id, dat, err, g); end
            vectors++; if (!sok || !stb || !idl) begin
                miscompares++; $display("[TB] FAIL rand_protocol[%0d]: start=%b stable=%b idle=%b required 1/1/1", t, sok, stb, idl); end
            model_ptr = (g + 1) % NREQ;
        end
        done_thresh = 0;
    endtask

    task automatic test_async_reset();
        int bad;
        req_op[2 +: 2] = 2'b11;
        req_valid = 4'b0010;
        @(posedge clk);
        #2 req_valid = '0;
        repeat (3) @(posedge clk);
        #3;
        vectors++; if (busy !== 1'b1 || pau_start !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_pre_exec: busy=%b start=%b required 1/1", busy, pau_start); end
        req_valid = '1;
        #2 rst = 1'b1;
        #1;
        vectors++; if ({req_ready, pau_start, pau_op, pau_a, pau_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 60'd0) begin
            miscompares++; $display("[TB] FAIL arst_immediate: busy=%b start=%b op=%b a=%h ready=%b required zero", busy, pau_start, pau_op, pau_a, req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        #1 rst = 1'b0;
        model_ptr = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (rsp_valid || busy) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("[TB] FAIL arst_no_stale: got %0d active cycles required 0", bad); end
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL arst_ptr_zero: got %b required 0001", req_ready); end
        req_valid = '0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        $display("[TB] pau_op_scheduler bench start");
        test_reset();
        test_single_add();
        do_reset();
        test_fairness();
        test_backpressure();
        test_late_div();
`ifdef PAU_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
